// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, branch redirect and decode-side handshake of the prefetch stage.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                    o_imem_req;
  logic [31:0]             o_imem_addr;
  logic                    i_imem_ack;
  logic [31:0]             i_imem_data;
  logic                    i_PCSrc;
  logic [31:0]             i_branch_addr;
  logic                    o_valid;
  logic                    i_ready;
  logic [31:0]             o_next_pc;
  logic [31:0]             o_data;
  logic [$clog2(DEPTH):0]  o_count;
  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_next_pc, o_data, o_count,
    input  i_imem_ack, i_imem_data, i_PCSrc, i_branch_addr, i_ready
  );
  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_next_pc, o_data, o_count,
    output i_imem_ack, i_imem_data, i_PCSrc, i_branch_addr, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch with a small first-word-fall-through buffer and branch redirect flush.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          req, push, pop, valid;
  assign valid = cnt_q != '0;
  assign head  = mem_q[rd_q];
  always_comb begin
    req     = !i_rst && state_q == IDLE && !bus.i_PCSrc && cnt_q < FULL;
    push    = state_q == WAIT && bus.i_imem_ack && !bus.i_PCSrc;
    pop     = valid && bus.i_ready && !bus.i_PCSrc;
    // an ack in WAIT or DROP always ends the outstanding request, redirect or not
    state_d = state_q == IDLE ? (req ? WAIT : IDLE)
            : bus.i_imem_ack ? IDLE
            : bus.i_PCSrc ? DROP : state_q;
    pc_d    = bus.i_PCSrc ? bus.i_branch_addr : push ? pc_q + 32'd4 : pc_q;
    wr_d    = bus.i_PCSrc ? '0 : wr_q + AW'(push);
    rd_d    = bus.i_PCSrc ? '0 : rd_q + AW'(pop);
    cnt_d   = bus.i_PCSrc ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= {pc_q + 32'd4, bus.i_imem_data};
  end
  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_valid     = valid;
  assign bus.o_next_pc   = valid ? head[63:32] : '0;
  assign bus.o_data      = valid ? head[31:0] : '0;
  assign bus.o_count     = cnt_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random imem latency, backpressure and redirects checked against a queue-based fetch model.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] out_addr = '0;
  logic [31:0] p_target = '0;
  logic outstanding = 0, stale = 0, ghost = 0, started = 0, force_rst = 1;
  logic p_rst = 0, p_pcsrc = 0, p_ack = 0, p_ack_real = 0, p_req = 0;
  int wait_cnt = 0;
  int pcsrc_pct = 0, ready_pct = 100, lat_max = 1;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // one clock of the environment: apply what the DUT saw last cycle to the model, then drive new inputs
  task automatic cycle();
    @(posedge clk);
    #1;
    if (p_rst) begin
      ghost = outstanding && !p_ack_real;
      outstanding = 0;
      stale = 0;
      q.delete();
      exp_pc = RESET_PC;
    end else begin
      if (p_ack_real) outstanding = 0;
      if (p_pcsrc) begin
        q.delete();
        exp_pc = p_target;
        stale = outstanding;
      end else if (p_ack_real && !stale) begin
        q.push_back({out_addr + 32'd4, word(out_addr)});
        exp_pc = out_addr + 32'd4;
      end
      if (p_req) begin
        outstanding = 1;
        stale = 0;
        out_addr = exp_pc;
        wait_cnt = $urandom_range(1, lat_max);
      end
    end
    p_rst = force_rst;
    rst = force_rst;
    p_ack = 0;
    p_ack_real = 0;
    if (ghost) begin
      p_ack = 1;
      ghost = 0;
    end else if (outstanding) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        p_ack = 1;
        p_ack_real = 1;
      end
    end
    bus.i_imem_ack  = p_ack;
    bus.i_imem_data = p_ack_real ? word(out_addr) : $urandom;
    p_pcsrc = !force_rst && ($urandom_range(0, 99) < pcsrc_pct);
    case ($urandom_range(0, 4))
      0: p_target = 32'h0000_0100;
      1: p_target = 32'h0000_0200;
      2: p_target = 32'h0000_0300;
      3: p_target = 32'hFFFF_FFFC;
      default: p_target = $urandom;
    endcase
    bus.i_PCSrc       = p_pcsrc;
    bus.i_branch_addr = p_pcsrc ? p_target : $urandom;
    bus.i_ready       = $urandom_range(0, 99) < ready_pct;
    #1;
    p_req = bus.o_imem_req;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("req", bus.o_imem_req, !rst && !outstanding && q.size() < DEPTH && !bus.i_PCSrc);
        if (bus.o_imem_req) check("req_addr", bus.o_imem_addr, exp_pc);
        check("count", bus.o_count, q.size());
        check("valid", bus.o_valid, q.size() != 0);
        if (q.size() != 0) begin
          check("next_pc", bus.o_next_pc, q[0][63:32]);
          check("data", bus.o_data, q[0][31:0]);
          if (bus.i_ready && !bus.i_PCSrc && !rst) void'(q.pop_front());
        end else begin
          check("idle_next_pc", bus.o_next_pc, 0);
          check("idle_data", bus.o_data, 0);
        end
      end
    end
  end
  initial begin
    bus.i_imem_ack = 0;
    bus.i_imem_data = '0;
    bus.i_PCSrc = 0;
    bus.i_branch_addr = '0;
    bus.i_ready = 0;
    cycle();
    started = 1;
    cycle();
    check("rst_addr", bus.o_imem_addr, RESET_PC);
    check("rst_req", bus.o_imem_req, 0);
    force_rst = 0;
    repeat (30) cycle();
    ready_pct = 0;
    repeat (20) cycle();
    check("full_count", bus.o_count, DEPTH);
    check("full_noreq", bus.o_imem_req, 0);
    ready_pct = 100;
    cycle();
    ready_pct = 0;
    repeat (6) cycle();
    pcsrc_pct = 8;
    ready_pct = 60;
    lat_max = 3;
    repeat (3000) cycle();
    pcsrc_pct = 30;
    ready_pct = 20;
    repeat (1000) cycle();
    pcsrc_pct = 0;
    ready_pct = 100;
    begin
      int n = 0;
      while (!(outstanding && wait_cnt >= 2) && n < 200) begin
        cycle();
        n++;
      end
      check("rst_wait_found", n < 200, 1);
    end
    force_rst = 1;
    cycle();
    force_rst = 0;
    cycle();
    check("post_rst_count", bus.o_count, 0);
    check("post_rst_valid", bus.o_valid, 0);
    check("post_rst_req", bus.o_imem_req, 1);
    check("post_rst_addr", bus.o_imem_addr, RESET_PC);
    repeat (20) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage between instruction memory and the IF/ID boundary of the pipeline CPU.
- Generates sequential fetch addresses and issues one request at a time to a variable-latency instruction memory.
- Buffers returned words with their next PC (PC+4) in a small FIFO and presents them to the decode stage under a valid/ready handshake.
- Flushes the buffer and redirects fetch when the MEM stage resolves a taken branch (PCSrc / branch address).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- o_imem_req  out  1  single-cycle fetch request strobe.
- o_imem_addr  out  32  fetch address; valid when o_imem_req=1, held stable until ack.
- i_imem_ack  in  1  single-cycle response strobe; i_imem_data valid in the same cycle.
- i_imem_data  in  32  instruction word.
- i_PCSrc  in  1  taken-branch redirect from the MEM stage.
- i_branch_addr  in  32  redirect target; sampled when i_PCSrc=1.
- o_valid  out  1  head entry available to decode.
- i_ready  in  1  decode accepts the head entry this cycle.
- o_next_pc  out  32  PC+4 of the head instruction.
- o_data  out  32  head instruction word.
- o_count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (i_rst=1 at edge): fetch_pc=RESET_PC, FSM=IDLE, count=0, rd/wr pointers=0, o_imem_req=0, o_imem_addr=RESET_PC, o_valid=0. o_next_pc and o_data read 0.
- Reset has priority over every other input. Reset mid-request moves the FSM to IDLE, and a late ack is ignored because the FSM is IDLE.
- FSM states:
  - IDLE: if no redirect and count<DEPTH, assert o_imem_req for one cycle with o_imem_addr=fetch_pc, then go to WAIT. Otherwise stay.
  - WAIT: wait for i_imem_ack. On ack with no redirect, push {fetch_pc+4, i_imem_data}, set fetch_pc+=4, go to IDLE. Ack arrives at the earliest 1 cycle after the request cycle.
  - DROP: a wrong-path request is outstanding. On ack, discard the data and go to IDLE. No push.
- Issue rule: count<DEPTH is checked in IDLE with one outstanding at most. A push is therefore always legal on ack, even if no pop occurs.
- Pop: o_valid & i_ready removes the head entry. Pop and push in the same cycle leave count unchanged; this is legal at full and at empty+1.
- First-word fall-through: o_valid=(count!=0). o_next_pc and o_data are driven combinationally from the head entry, and are 0 when o_valid=0.
- Redirect (i_PCSrc=1, no reset):
  - Pointers and count are cleared; o_valid=0 next cycle. fetch_pc=i_branch_addr.
  - Any pop or ack-push in that cycle is suppressed.
  - IDLE → IDLE; no request is issued in the redirect cycle, and a request to the target is issued the following cycle.
  - WAIT without ack → DROP.
  - WAIT with ack → IDLE (data discarded).
  - DROP without ack → DROP, with fetch_pc updated to the new target.
  - DROP with ack → IDLE.
- Address arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Low two bits are passed through unmodified.
- Pointers wrap modulo DEPTH.
- Throughput: one instruction per 2 cycles at best with 1-cycle memory latency (request cycle plus ack cycle).

Test Plan:
- Reset then free-run with 1-cycle ack and i_ready=1:
  - requests at 0x0, 0x4, 0x8;
  - decode sees o_next_pc=0x4, 0x8, 0xC with the matching words;
  - o_count never exceeds 1.
- Backpressure with i_ready=0, DEPTH=4: exactly 4 requests (0x0–0xC), then o_imem_req stays 0 with o_count=4. Raising i_ready for one cycle gives o_count=3, and the next request goes to 0x10.
- Redirect while WAIT:
  - request to 0x8 outstanding; i_PCSrc=1 with i_branch_addr=0x100;
  - the ack 2 cycles later is dropped (no push, o_valid stays 0);
  - next request is to 0x100, and its entry shows o_next_pc=0x104.
- Redirect coincident with ack and with pop at full queue: count goes to 0, no push/pop effects, next request is to the target address.
- Double redirect in DROP (0x200 then 0x300 before ack): the single late ack is discarded and the next request goes to 0x300.
- Wrap and reset:
  - redirect to 0xFFFF_FFFC; its entry shows o_next_pc=0x0 and the following request goes to 0x0;
  - assert i_rst while WAIT, then ack: o_valid=0, o_count=0, and the next request goes to RESET_PC.
